countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 14 +
 rtl/countdown_timer_if.sv | 14 +
 rtl/countdown_timer_digit.sv | 18 +
 rtl/countdown_timer.sv | 48 ++++
 tb/tb_countdown_timer.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// countdown_pkg: shared state type, digit limits and field indices for the MM:SS countdown timer
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam int SEC_ONES = 0;
  localparam int SEC_TENS = 1;
  localparam int MIN_ONES = 2;
  localparam int MIN_TENS = 3;
  function automatic logic bcd_legal(logic [15:0] v);
    return v[4*MIN_TENS+:4] <= DIGIT_MAX && v[4*MIN_ONES+:4] <= DIGIT_MAX &&
           v[4*SEC_TENS+:4] <= SEC_TENS_MAX && v[4*SEC_ONES+:4] <= DIGIT_MAX;
  endfunction
endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control inputs and MM:SS status outputs of the countdown timer
interface countdown_timer_if;
  logic tick;
  logic load;
  logic [15:0] load_val;
  logic start;
  logic pause;
  logic [15:0] digits;
  logic running;
  logic done;
  logic load_err;
  modport master (output tick, load, load_val, start, pause, input digits, running, done, load_err);
  modport slave (input tick, load, load_val, start, pause, output digits, running, done, load_err);
endinterface

// File: rtl/countdown_timer_digit.sv
// bcd_down_digit: one BCD down-counting digit that wraps 0 to MAX and flags a borrow
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       borrow
);
  assign borrow = en && q == 4'd0;
  always_ff @(posedge clk)
    if (!rst_n) q <= 4'd0;
    else if (ld) q <= ld_val;
    else if (en) q <= q == 4'd0 ? MAX : q - 4'd1;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown with load validation and an IDLE/RUN/PAUSE/DONE controller
module countdown_timer
  import countdown_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  countdown_timer_if.slave bus
);
  state_t state, nxt;
  logic [15:0] cnt;
  logic [3:0] en, br;
  logic ok, ld, tick_en, expire, done_q, err_q;
  assign ok = bcd_legal(bus.load_val);
  assign ld = bus.load && ok;
  assign tick_en = bus.tick && state == RUN && !bus.load;
  assign expire = tick_en && cnt == 16'h0001;
  assign en = {br[2:0], tick_en};
  for (genvar g = 0; g < 4; g++) begin : g_dig
    bcd_down_digit #(.MAX(g == SEC_TENS ? SEC_TENS_MAX : DIGIT_MAX)) u_dig (
      .clk(clk), .rst_n(rst_n), .en(en[g]), .ld(ld), .ld_val(bus.load_val[4*g+:4]),
      .q(cnt[4*g+:4]), .borrow(br[g])
    );
  end
  // start outranks pause even when start itself is ignored; reaching 00:00 beats a coincident pause
  always_comb begin
    nxt = state;
    if (bus.load) nxt = ok ? IDLE : state;
    else begin
      nxt = bus.start ? (state == IDLE && |cnt ? RUN : state) :
            bus.pause ? (state == RUN ? PAUSE : state == PAUSE ? RUN : state) : state;
      if (expire) nxt = DONE;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      done_q <= expire;
      err_q <= bus.load && !ok;
    end
  assign bus.digits = cnt;
  assign bus.running = state == RUN;
  assign bus.done = done_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench comparing the timer against a seconds-based reference model
module tb_countdown_timer;
  typedef struct packed {
    logic [15:0] d;
    logic r;
    logic dn;
    logic e;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  countdown_timer_if bus ();
  countdown_timer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int secs = 0;
  int st = 0;
  int m_done = 0;
  int m_err = 0;
  function automatic logic [15:0] to_bcd(int s);
    int m = s / 60;
    int x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction
  function automatic bit legal(logic [15:0] v);
    return v[15:12] <= 9 && v[11:8] <= 9 && v[7:4] <= 5 && v[3:0] <= 9;
  endfunction
  function automatic int to_secs(logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction
  task automatic cyc(bit r, bit t, bit l, logic [15:0] lv, bit s, bit p);
    int nst;
    @(negedge clk);
    rst_n = r;
    bus.tick = t;
    bus.load = l;
    bus.load_val = lv;
    bus.start = s;
    bus.pause = p;
    // states: 0 idle, 1 run, 2 pause, 3 done
    m_done = 0;
    m_err = 0;
    if (!r) begin
      secs = 0;
      st = 0;
    end else if (l) begin
      if (legal(lv)) begin
        secs = to_secs(lv);
        st = 0;
      end else m_err = 1;
    end else begin
      nst = st;
      if (s) begin
        if (st == 0 && secs > 0) nst = 1;
      end else if (p) nst = st == 1 ? 2 : st == 2 ? 1 : st;
      if (st == 1 && t) begin
        secs--;
        if (secs == 0) begin
          nst = 3;
          m_done = 1;
        end
      end
      st = nst;
    end
    sb.push_back('{to_bcd(secs), st == 1, m_done[0], m_err[0]});
  endtask
  task automatic idle(int n);
    repeat (n) cyc(1, 0, 0, 16'h0, 0, 0);
  endtask
  task automatic ticks(int n);
    repeat (n) begin
      cyc(1, 1, 0, 16'h0, 0, 0);
      cyc(1, 0, 0, 16'h0, 0, 0);
    end
  endtask
  initial begin
    exp_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        a = '{bus.digits, bus.running, bus.done, bus.load_err};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL vec%0d digits/running/done/load_err got %h/%b/%b/%b exp %h/%b/%b/%b",
                   vectors, a.d, a.r, a.dn, a.e, e.d, e.r, e.dn, e.e);
        end
      end
    end
  end
  initial begin
    bus.tick = 0;
    bus.load = 0;
    bus.load_val = 0;
    bus.start = 0;
    bus.pause = 0;
    cyc(0, 0, 0, 16'h0, 0, 0);
    cyc(0, 1, 1, 16'h0123, 1, 0);
    idle(1);
    cyc(1, 0, 1, 16'h0005, 0, 0);
    cyc(1, 0, 0, 16'h0, 1, 0);
    ticks(5);
    cyc(1, 0, 0, 16'h0, 1, 0);
    ticks(1);
    cyc(1, 0, 1, 16'h1000, 0, 0);
    cyc(1, 0, 0, 16'h0, 1, 0);
    ticks(1);
    cyc(1, 0, 1, 16'h0070, 0, 0);
    idle(1);
    cyc(1, 0, 1, 16'h0000, 0, 0);
    cyc(1, 0, 0, 16'h0, 1, 0);
    ticks(1);
    cyc(1, 0, 1, 16'h0130, 0, 0);
    cyc(1, 0, 0, 16'h0, 1, 0);
    cyc(1, 0, 0, 16'h0, 0, 1);
    ticks(3);
    cyc(1, 0, 0, 16'h0, 0, 1);
    ticks(1);
    cyc(1, 1, 0, 16'h0, 0, 1);
    cyc(1, 0, 1, 16'h0002, 0, 0);
    cyc(1, 0, 0, 16'h0, 1, 0);
    cyc(0, 1, 0, 16'h0, 0, 0);
    idle(2);
    cyc(1, 0, 1, 16'h0010, 0, 0);
    cyc(1, 0, 0, 16'h0, 1, 0);
    cyc(1, 1, 1, 16'h0200, 0, 0);
    ticks(2);
    cyc(1, 0, 1, 16'h0001, 0, 0);
    cyc(1, 0, 0, 16'h0, 1, 0);
    cyc(1, 1, 0, 16'h0, 0, 1);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] lv;
      lv = $urandom_range(0, 3) == 0 ? 16'($urandom) : to_bcd($urandom_range(0, 150));
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0, lv,
          $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
    end
    idle(1);
    repeat (4) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
